// File: rtl/lif_sched_pkg.sv
// Shared definitions for the time-multiplexed LIF layer scheduler:
// data width, FSM state encoding and the saturating 8-bit adder.
package lif_sched_pkg;

  localparam int DW = 8;
  localparam logic [DW-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_UPDATE,
    ST_DONE
  } state_e;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DW] ? SAT_MAX : sum[DW-1:0];
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Single-neuron LIF update: refractory countdown, saturating integrate,
// threshold/fire and leak. Shared by all neurons of the layer.
module lif_update_unit
  import lif_sched_pkg::*;
(
  input  logic [DW-1:0] v_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] acc_in,
  input  logic [DW-1:0] threshold,
  input  logic [DW-1:0] decay,
  input  logic [DW-1:0] refractory_period,
  output logic [DW-1:0] v_out,
  output logic [DW-1:0] r_out,
  output logic          spike
);

  logic [DW-1:0] sum;

  // NOTE: every output gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sum   = sat_add(v_in, acc_in);
    v_out = '0;
    r_out = '0;
    spike = 1'b0;
    if (r_in != '0) begin
      r_out = r_in - 1'b1;
    end else if (sum >= threshold) begin
      spike = 1'b1;
      r_out = refractory_period;
    end else if (sum > decay) begin
      v_out = sum - decay;
    end
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// Sequences one shared accumulator and LIF update unit across N neurons,
// holding per-neuron membrane and refractory state in register arrays.
module lif_layer_scheduler
  import lif_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              start,
  input  logic [M-1:0]                      input_spikes,
  input  logic [N*M*DW-1:0]                 weights,
  input  logic [DW-1:0]                     threshold,
  input  logic [DW-1:0]                     decay,
  input  logic [DW-1:0]                     refractory_period,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] dbg_sel,
  output logic                              busy,
  output logic                              done,
  output logic [N-1:0]                      spikes_out,
  output logic [DW-1:0]                     dbg_potential
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [IW-1:0] I_LAST = IW'(M - 1);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] i_q, i_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [M-1:0]  spk_in_q, spk_in_d;
  logic [DW-1:0] thr_q, thr_d;
  logic [DW-1:0] dec_q, dec_d;
  logic [DW-1:0] rp_q, rp_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  spikes_out_q, spikes_out_d;
  logic [DW-1:0] pot_q [N];
  logic [DW-1:0] pot_d [N];
  logic [DW-1:0] ref_q [N];
  logic [DW-1:0] ref_d [N];

  logic [31:0]   w_idx;
  logic [DW-1:0] w_sel;
  logic [DW-1:0] v_new, r_new;
  logic          spike_new;

  // Weights are not latched: only the current (n, i) byte is consumed.
  always_comb begin
    w_idx = (32'(n_q) * 32'(M) + 32'(i_q)) * 32'(DW);
    w_sel = weights[w_idx +: DW];
  end

  lif_update_unit u_update (
    .v_in              (pot_q[n_q]),
    .r_in              (ref_q[n_q]),
    .acc_in            (acc_q),
    .threshold         (thr_q),
    .decay             (dec_q),
    .refractory_period (rp_q),
    .v_out             (v_new),
    .r_out             (r_new),
    .spike             (spike_new)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    i_d          = i_q;
    acc_d        = acc_q;
    spk_in_d     = spk_in_q;
    thr_d        = thr_q;
    dec_d        = dec_q;
    rp_d         = rp_q;
    shadow_d     = shadow_q;
    spikes_out_d = spikes_out_q;
    pot_d        = pot_q;
    ref_d        = ref_q;

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            spk_in_d = input_spikes;
            thr_d    = threshold;
            dec_d    = decay;
            rp_d     = refractory_period;
            n_d      = '0;
            i_d      = '0;
            acc_d    = '0;
            shadow_d = '0;
            state_d  = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (spk_in_q[i_q]) acc_d = sat_add(acc_q, w_sel);
          if (i_q == I_LAST) state_d = ST_UPDATE;
          else               i_d     = i_q + 1'b1;
        end
        ST_UPDATE: begin
          pot_d[n_q]    = v_new;
          ref_d[n_q]    = r_new;
          shadow_d[n_q] = spike_new;
          if (n_q == N_LAST) begin
            // Publish on entry to DONE so spikes_out is valid alongside done.
            spikes_out_d = shadow_d;
            state_d      = ST_DONE;
          end else begin
            n_d     = n_q + 1'b1;
            i_d     = '0;
            acc_d   = '0;
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      i_q          <= '0;
      acc_q        <= '0;
      spk_in_q     <= '0;
      thr_q        <= '0;
      dec_q        <= '0;
      rp_q         <= '0;
      shadow_q     <= '0;
      spikes_out_q <= '0;
      // NOTE: the neuron arrays are small flop banks, not RAM, so they are
      // cleared by reset; a RAM-backed version would need an init sweep.
      pot_q        <= '{default: '0};
      ref_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      i_q          <= i_d;
      acc_q        <= acc_d;
      spk_in_q     <= spk_in_d;
      thr_q        <= thr_d;
      dec_q        <= dec_d;
      rp_q         <= rp_d;
      shadow_q     <= shadow_d;
      spikes_out_q <= spikes_out_d;
      pot_q        <= pot_d;
      ref_q        <= ref_d;
    end
  end

  always_comb begin
    dbg_potential = '0;
    if (32'(dbg_sel) < 32'(N)) dbg_potential = pot_q[dbg_sel];
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign spikes_out = spikes_out_q;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: a behavioural LIF model pushes the
// expected result of each timestep to a scoreboard, popped on done.
module tb_lif_layer_scheduler;

  localparam int N  = 4;
  localparam int M  = 8;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic             clk = 1'b0;
  logic             reset, enable, start;
  logic [M-1:0]     input_spikes;
  logic [N*M*8-1:0] weights;
  logic [7:0]       threshold, decay, refractory_period;
  logic [SW-1:0]    dbg_sel;
  logic             busy, done;
  logic [N-1:0]     spikes_out;
  logic [7:0]       dbg_potential;

  always #5 clk = ~clk;

  lif_layer_scheduler #(.N(N), .M(M)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .start             (start),
    .input_spikes      (input_spikes),
    .weights           (weights),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .dbg_sel           (dbg_sel),
    .busy              (busy),
    .done              (done),
    .spikes_out        (spikes_out),
    .dbg_potential     (dbg_potential)
  );

  typedef struct packed {
    logic [N-1:0]   spk;
    logic [N*8-1:0] pot;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mv[N];
  int   mr[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_w(input int n_only, input logic [7:0] w_on, input logic [7:0] w_off);
    for (int n = 0; n < N; n++)
      for (int i = 0; i < M; i++)
        weights[(n*M+i)*8 +: 8] = (n_only < 0 || n == n_only) ? w_on : w_off;
  endtask

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mr[n] = 0;
    end
  endtask

  // Reference LIF step taken from the current inputs at the moment of start.
  task automatic model_push();
    exp_t e;
    int   acc, s;
    e = '0;
    for (int n = 0; n < N; n++) begin
      acc = 0;
      for (int i = 0; i < M; i++)
        if (input_spikes[i]) acc += int'(weights[(n*M+i)*8 +: 8]);
      if (acc > 255) acc = 255;
      if (mr[n] > 0) begin
        mr[n]--;
        mv[n] = 0;
      end else begin
        s = (mv[n] + acc > 255) ? 255 : mv[n] + acc;
        if (s >= int'(threshold)) begin
          e.spk[n] = 1'b1;
          mv[n]    = 0;
          mr[n]    = int'(refractory_period);
        end else begin
          mv[n] = (s > int'(decay)) ? s - int'(decay) : 0;
        end
      end
      e.pot[n*8 +: 8] = 8'(mv[n]);
    end
    sb.push_back(e);
  endtask

  // One timestep; optional 5-cycle enable stall and a stray start while busy.
  // Config inputs are scrambled mid-run to prove they were latched.
  task automatic run_ts(input string tag, input int stall_at, input int restart_at,
                        input int exp_lat);
    int         cnt;
    exp_t       e;
    logic [7:0] s_in, s_thr, s_dec, s_rp;
    @(negedge clk);
    start = 1'b1;
    model_push();
    s_in = input_spikes; s_thr = threshold; s_dec = decay; s_rp = refractory_period;
    @(posedge clk); #1;
    start = 1'b0;
    cnt   = 1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    while (!done && cnt < 200) begin
      @(negedge clk);
      start  = (cnt == restart_at);
      enable = !(stall_at > 0 && cnt >= stall_at && cnt < stall_at + 5);
      if (cnt == 2) begin
        input_spikes      = ~s_in;
        threshold         = s_thr ^ 8'h55;
        decay             = s_dec ^ 8'h0c;
        refractory_period = s_rp ^ 8'h03;
      end
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0; enable = 1'b1;
    input_spikes = s_in; threshold = s_thr; decay = s_dec; refractory_period = s_rp;
    check({tag, " done latency"}, 32'(cnt), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " scoreboard"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " spikes_out"}, 32'(spikes_out), 32'(e.spk));
      for (int n = 0; n < N; n++) begin
        dbg_sel = SW'(n);
        #1;
        check($sformatf("%s pot[%0d]", tag, n), 32'(dbg_potential), 32'(e.pot[n*8 +: 8]));
      end
    end
  endtask

  // Abort a timestep with a 2-cycle reset during ACCUM; nothing is written back.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " spikes_out"}, 32'(spikes_out), 32'd0);
    for (int n = 0; n < N; n++) begin
      dbg_sel = SW'(n);
      #1;
      check($sformatf("%s pot[%0d]", tag, n), 32'(dbg_potential), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    input_spikes = '0; weights = '0; threshold = '0; decay = '0;
    refractory_period = '0; dbg_sel = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset spikes_out", 32'(spikes_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Integration without refractory: 35 then 70.
    set_w(-1, 8'd10, 8'd0);
    input_spikes = 8'h0F; threshold = 8'd100; decay = 8'd5; refractory_period = 8'd0;
    run_ts("int_t1", 0, 0, 37);
    run_ts("int_t2", 0, 0, 37);
    reset_mid("rst_a");

    // Refractory of 2; first timestep also exercises stray start and a stall.
    refractory_period = 8'd2;
    run_ts("ref_t1", 3, 10, 42);
    run_ts("ref_t2", 0, 0, 37);
    run_ts("ref_t3", 0, 0, 37);
    run_ts("ref_t4", 0, 0, 37);
    run_ts("ref_t5", 0, 0, 37);
    run_ts("ref_t6", 0, 0, 37);

    // Saturation of accumulator and membrane.
    set_w(-1, 8'hFF, 8'hFF);
    input_spikes = 8'hFF; threshold = 8'd255; refractory_period = 8'd0;
    run_ts("sat", 0, 0, 37);
    reset_mid("rst_b");

    // Per-neuron weights: only neuron 2 is driven.
    set_w(2, 8'd50, 8'd0);
    input_spikes = 8'h01; threshold = 8'd40; decay = 8'd5;
    run_ts("pern", 0, 0, 37);

    // Zero threshold: every non-refractory neuron fires.
    threshold = 8'd0;
    run_ts("thr0", 0, 0, 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
